// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-add multiplier.
// One partial product per clock; registered done_o pulse with result.
module shift_add_mult #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [WIDTH_A-1:0]         a_i,
  input  logic [WIDTH_B-1:0]         b_i,
  input  logic                       clr_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [WIDTH_A+WIDTH_B-1:0] product_o
);

  localparam int WIDTH_P = WIDTH_A + WIDTH_B;
  localparam int CNT_W   = $clog2(WIDTH_B + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH_B);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH_P-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH_B-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH_P-1:0]   acc_q, acc_d;
  logic [WIDTH_P-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH_P-1:0]   sum;
  logic                 last;

  assign sum  = acc_q + (b_sh_q[0] ? a_sh_q : '0);
  assign last = (cnt_q == CNT_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: clear wins; starts only taken in IDLE.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start_i) state_d = S_CALC;
        S_CALC:  if (last) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: load, add-shift, capture product on last step.
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    acc_d  = acc_q;
    prod_d = prod_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      a_sh_d = '0;
      b_sh_d = '0;
      acc_d  = '0;
      prod_d = '0;
      cnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_sh_d = WIDTH_P'(a_i);
            b_sh_d = b_i;
            acc_d  = '0;
            cnt_d  = CNT_LOAD;
          end
        end
        S_CALC: begin
          acc_d  = sum;
          a_sh_d = a_sh_q << 1;
          b_sh_d = b_sh_q >> 1;
          cnt_d  = cnt_q - CNT_ONE;
          if (last) prod_d = sum;
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_DONE);
    product_o = prod_q;
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult.
// Directed vectors plus back-to-back random pairs.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  a_i = '0;
  logic [7:0]  b_i = '0;
  logic        clr_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [15:0] product_o;

  typedef struct packed {
    logic [15:0] p;
    logic [31:0] c;
  } exp_t;

  exp_t        q[$];
  logic [31:0] cyc = '0;
  int          nchk = 0;
  int          nerr = 0;
  int          nstart = 0;
  int          ndone = 0;

  shift_add_mult dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .clr_i     (clr_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done_o) begin
      ndone++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("product", {16'h0, product_o}, {16'h0, e.p});
        chk("latency", cyc, e.c);
      end
    end
  end

  // Issue a start at the current negedge; leaves us one cycle later.
  task automatic go(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    start_i = 1'b1;
    a_i = a;
    b_i = b;
    e.p = {8'h0, a} * {8'h0, b};
    e.c = cyc + 32'd9;
    q.push_back(e);
    nstart++;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    int nb;
    logic [7:0] va [4];
    logic [7:0] vb [4];
    va = '{8'hFF, 8'h00, 8'h01, 8'h3C};
    vb = '{8'hFF, 8'hA5, 8'h80, 8'h11};

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy_o}, 32'd0);
    chk("rst_done", {31'h0, done_o}, 32'd0);
    chk("rst_prod", {16'h0, product_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic vector and busy duration
    go(8'h0C, 8'h0B);
    nb = 0;
    for (int i = 0; i < 11; i++) begin
      if (busy_o) nb++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, 32'd9);
    chk("basic_hold", {16'h0, product_o}, 32'h84);

    // Extremes, each in its own slot
    for (int i = 0; i < 4; i++) begin
      go(va[i], vb[i]);
      repeat (10) @(negedge clk);
    end

    // Reset mid-CALC: outputs clear at once, no done afterwards
    go(8'h55, 8'h03);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    void'(q.pop_back());
    nstart--;
    #1;
    chk("midrst_busy", {31'h0, busy_o}, 32'd0);
    chk("midrst_done", {31'h0, done_o}, 32'd0);
    chk("midrst_prod", {16'h0, product_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("postrst_busy", {31'h0, busy_o}, 32'd0);

    // Start held high with changing operands while busy
    go(8'h03, 8'h05);
    start_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_i = 8'(i + 7);
      b_i = 8'(i + 9);
      @(negedge clk);
    end
    go(8'h02, 8'h02);
    repeat (10) @(negedge clk);

    // Abort in CALC cycle 4 after a nonzero product is held
    go(8'h21, 8'h07);
    repeat (3) @(negedge clk);
    clr_i = 1'b1;
    void'(q.pop_back());
    nstart--;
    @(negedge clk);
    clr_i = 1'b0;
    chk("clr_busy", {31'h0, busy_o}, 32'd0);
    chk("clr_done", {31'h0, done_o}, 32'd0);
    chk("clr_prod", {16'h0, product_o}, 32'd0);
    repeat (12) @(negedge clk);

    // Clear together with start in IDLE: no start
    clr_i = 1'b1;
    start_i = 1'b1;
    a_i = 8'h09;
    b_i = 8'h09;
    @(negedge clk);
    clr_i = 1'b0;
    start_i = 1'b0;
    chk("clrstart_busy", {31'h0, busy_o}, 32'd0);
    repeat (12) @(negedge clk);

    // Back-to-back random pairs at peak throughput
    for (int i = 0; i < 1000; i++) begin
      go(8'($urandom_range(255)), 8'($urandom_range(255)));
      repeat (9) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    chk("queue_empty", q.size(), 32'd0);
    chk("done_count", ndone, nstart);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
